// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmit states, frame sizes and falling-edge milestones.
package ps2_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StRts,
    StBits,
    StAck,
    StWaitIdle
  } ps2_state_e;

  localparam int unsigned PS2_DATA_BITS = 8;
  localparam int unsigned FE_CNT_W      = 4;

  // Device clock falling-edge numbers within one host-to-device frame
  localparam int unsigned PARITY_FE = 9;
  localparam int unsigned STOP_FE   = 10;
  localparam int unsigned ACK_FE    = 11;

  function automatic logic odd_parity(input logic [PS2_DATA_BITS-1:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for a raw PS/2 line plus a falling-edge strobe on the synced value.
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic sync,
  output logic fe
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Idle PS/2 lines float high, so reset to 1 to avoid a false edge after reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= line;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync = sync_q;
  assign fe   = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 byte transmitter: inhibit, request-to-send, clocked-out bits, ACK check.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 10000,
  parameter int unsigned TIMEOUT_CYCLES = 1500000,
  parameter int unsigned CNT_W          = 21
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tx_start,
  input  logic [PS2_DATA_BITS-1:0] tx_data,
  input  logic                     ps2_clk_in,
  input  logic                     ps2_data_in,
  output logic                     ps2_clk_oe,
  output logic                     ps2_data_oe,
  output logic                     tx_busy,
  output logic                     tx_done,
  output logic                     tx_err,
  output logic                     tx_timeout
);

  localparam logic [CNT_W-1:0]    INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0]    TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [FE_CNT_W-1:0] PARITY_CNT   = FE_CNT_W'(PARITY_FE);
  localparam logic [FE_CNT_W-1:0] ACK_CNT      = FE_CNT_W'(ACK_FE);

  ps2_state_e state_q, state_d;

  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [PS2_DATA_BITS:0]   shift_q, shift_d;
  logic [FE_CNT_W-1:0]      fe_cnt_q, fe_cnt_d;
  logic                     ack_bad_q, ack_bad_d;
  logic                     clk_oe_q, clk_oe_d;
  logic                     data_oe_q, data_oe_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic                     timeout_q, timeout_d;

  logic clk_sync, clk_fe;
  logic data_sync, unused_data_fe;
  logic line_idle;
  logic in_frame;

  ps2_line_sync u_clk_sync (
    .clk  (clk),
    .rst  (rst),
    .line (ps2_clk_in),
    .sync (clk_sync),
    .fe   (clk_fe)
  );

  ps2_line_sync u_data_sync (
    .clk  (clk),
    .rst  (rst),
    .line (ps2_data_in),
    .sync (data_sync),
    .fe   (unused_data_fe)
  );

  assign line_idle = clk_sync & data_sync;
  assign in_frame  = state_q inside {StRts, StBits, StAck, StWaitIdle};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    fe_cnt_d  = fe_cnt_q;
    ack_bad_d = ack_bad_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    timeout_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        busy_d    = 1'b0;
        if (tx_start) begin
          shift_d   = {odd_parity(tx_data), tx_data};
          cnt_d     = '0;
          fe_cnt_d  = '0;
          ack_bad_d = 1'b0;
          busy_d    = 1'b1;
          clk_oe_d  = 1'b1;
          state_d   = StInhibit;
        end
      end
      StInhibit: begin
        if (cnt_q == INHIBIT_LAST) begin
          cnt_d     = '0;
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
          state_d   = StRts;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRts, StBits: begin
        if (clk_fe) begin
          cnt_d    = '0;
          fe_cnt_d = fe_cnt_q + 1'b1;
          // Edges 1..PARITY_FE shift out data then parity; the next one releases for stop
          if (fe_cnt_q < PARITY_CNT) begin
            data_oe_d = ~shift_q[0];
            shift_d   = shift_q >> 1;
            state_d   = StBits;
          end else begin
            data_oe_d = 1'b0;
            state_d   = StAck;
          end
        end
      end
      StAck: begin
        if (clk_fe) begin
          cnt_d     = '0;
          fe_cnt_d  = ACK_CNT;
          ack_bad_d = data_sync;
          state_d   = StWaitIdle;
        end
      end
      StWaitIdle: begin
        if (line_idle) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          done_d  = ~ack_bad_q;
          err_d   = ack_bad_q;
        end
      end
      default: state_d = StIdle;
    endcase

    // Device clock watchdog; any falling edge or a normal frame completion restarts or ends it
    if (in_frame && !clk_fe && !(state_q == StWaitIdle && line_idle)) begin
      if (cnt_q == TIMEOUT_LAST) begin
        state_d   = StIdle;
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        busy_d    = 1'b0;
        timeout_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      shift_q   <= '0;
      fe_cnt_q  <= '0;
      ack_bad_q <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      fe_cnt_q  <= fe_cnt_d;
      ack_bad_q <= ack_bad_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
    end
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign tx_busy     = busy_q;
  assign tx_done     = done_q;
  assign tx_err      = err_q;
  assign tx_timeout  = timeout_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a PS/2 device model clocks frames out, a queue holds expected bits.
module tb_ps2_host_tx;

  logic       clk;
  logic       rst;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_err;
  logic       tx_timeout;

  logic dev_clk;
  logic dev_data;

  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   last_fall   = 0;
  int   n_done      = 0;
  int   n_err       = 0;
  int   n_to        = 0;
  logic sb[$];

  ps2_host_tx #(
    .INHIBIT_CYCLES (20),
    .TIMEOUT_CYCLES (500),
    .CNT_W          (21)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .tx_err      (tx_err),
    .tx_timeout  (tx_timeout)
  );

  // Open-drain wired-AND of host pull-downs and device drive
  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_done)    n_done <= n_done + 1;
    if (tx_err)     n_err  <= n_err + 1;
    if (tx_timeout) n_to   <= n_to + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] d);
    for (int i = 0; i < 8; i++) sb.push_back(d[i]);
    sb.push_back(~^d);
    sb.push_back(1'b1);
  endtask

  task automatic send(input logic [7:0] d);
    tx_data  = d;
    tx_start = 1'b1;
    step();
    tx_start = 1'b0;
    push_frame(d);
  endtask

  // Device side: wait for request-to-send, clock n_fe falling edges, sample at each rise
  task automatic dev_frame(input int n_fe, input logic ack_level, output int hi);
    int   t;
    logic e;
    hi = 0;
    t  = 0;
    while (!(ps2_clk_in === 1'b1 && ps2_data_in === 1'b0) && t < 2000) begin
      if (ps2_clk_oe) hi++;
      step();
      t++;
    end
    check("rts_seen", 32'(t < 2000), 1);
    if (t >= 2000) return;
    repeat (20) step();
    for (int i = 1; i <= n_fe && i <= 10; i++) begin
      dev_clk   = 1'b0;
      last_fall = cyc;
      repeat (20) step();
      check("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check($sformatf("bit_fe%0d", i), 32'(ps2_data_in), 32'(e));
      end
      dev_clk = 1'b1;
      repeat (20) step();
    end
    if (n_fe >= 11) begin
      dev_data = ack_level;
      repeat (5) step();
      dev_clk   = 1'b0;
      last_fall = cyc;
      repeat (20) step();
      dev_clk  = 1'b1;
      dev_data = 1'b1;
    end
  endtask

  task automatic wait_end();
    int t;
    t = 0;
    while (!(tx_done || tx_err || tx_timeout) && t < 1000) begin
      step();
      t++;
    end
    check("end_seen", 32'(t < 1000), 1);
  endtask

  initial begin
    int d0, e0, t0, hi, any_drive, elapsed;

    rst      = 1'b0;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    dev_clk  = 1'b1;
    dev_data = 1'b1;

    // Reset and quiet idle
    repeat (3) step();
    check("reset_outputs", {26'd0, ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_err, tx_timeout},
          0);
    rst       = 1'b1;
    any_drive = 0;
    repeat (100) begin
      step();
      if (ps2_clk_oe || ps2_data_oe || tx_busy) any_drive = 1;
    end
    check("idle_quiet", any_drive, 0);

    // 0xED with good ACK
    d0 = n_done; e0 = n_err; t0 = n_to;
    send(8'hED);
    check("busy_after_accept", tx_busy, 1);
    dev_frame(11, 1'b0, hi);
    check("inhibit_len", hi, 20);
    wait_end();
    check("ed_done", tx_done, 1);
    check("ed_busy_low", tx_busy, 0);
    repeat (5) step();
    check("ed_done_cnt", n_done - d0, 1);
    check("ed_err_cnt", n_err - e0, 0);
    check("ed_to_cnt", n_to - t0, 0);
    check("ed_sb_drained", sb.size(), 0);

    // 0x00 with device refusing ACK
    d0 = n_done; e0 = n_err; t0 = n_to;
    send(8'h00);
    dev_frame(11, 1'b1, hi);
    wait_end();
    check("nak_err", tx_err, 1);
    repeat (5) step();
    check("nak_err_cnt", n_err - e0, 1);
    check("nak_done_cnt", n_done - d0, 0);
    check("nak_sb_drained", sb.size(), 0);

    // Device stops after 4 edges
    d0 = n_done; e0 = n_err; t0 = n_to;
    send(8'h5A);
    dev_frame(4, 1'b0, hi);
    wait_end();
    elapsed = cyc - last_fall;
    check("to_pulse", tx_timeout, 1);
    check("to_latency", 32'(elapsed >= 500 && elapsed <= 506), 1);
    check("to_lines", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
    check("to_busy", tx_busy, 0);
    repeat (5) step();
    check("to_cnt", n_to - t0, 1);
    check("to_other_cnt", (n_done - d0) + (n_err - e0), 0);
    sb.delete();

    // Start while busy is ignored; start on the done cycle is accepted
    d0 = n_done;
    send(8'hFF);
    repeat (3) step();
    tx_data  = 8'hAA;
    tx_start = 1'b1;
    step();
    tx_start = 1'b0;
    tx_data  = 8'h55;
    check("ignored_start_busy", tx_busy, 1);
    dev_frame(11, 1'b0, hi);
    wait_end();
    check("ff_done", tx_done, 1);
    check("ff_sb_drained", sb.size(), 0);
    tx_data  = 8'h3C;
    tx_start = 1'b1;
    step();
    tx_start = 1'b0;
    push_frame(8'h3C);
    check("b2b_busy", tx_busy, 1);
    check("b2b_inhibit", ps2_clk_oe, 1);
    dev_frame(11, 1'b0, hi);
    wait_end();
    check("b2b_done", tx_done, 1);
    repeat (5) step();
    check("b2b_done_cnt", n_done - d0, 2);

    // Reset in the middle of the data bits
    d0 = n_done; e0 = n_err; t0 = n_to;
    send(8'hED);
    dev_frame(5, 1'b0, hi);
    check("pre_reset_busy", tx_busy, 1);
    rst = 1'b0;
    step();
    check("rst_lines", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
    check("rst_busy", tx_busy, 0);
    rst = 1'b1;
    repeat (5) step();
    check("rst_no_pulse", (n_done - d0) + (n_err - e0) + (n_to - t0), 0);
    sb.delete();
    send(8'hED);
    dev_frame(11, 1'b0, hi);
    wait_end();
    check("post_rst_done", tx_done, 1);
    check("post_rst_sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
